// File: rtl/fpu_pkg.sv
// fpu_pkg: shared widths, FSM states and status bit positions for the FPU normalizer.
package fpu_pkg;
    localparam int EXP_W  = 6;
    localparam int MAN_W  = 25;
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
    localparam int IEXP_W = EXP_W + 2;
    localparam int DATA_W = 1 + EXP_W + MAN_W;

    localparam logic signed [IEXP_W-1:0] EXP_ONE = IEXP_W'(1);
    localparam logic signed [IEXP_W-1:0] EXP_MAX = IEXP_W'((1 << EXP_W) - 1);

    localparam int ST_OVF  = 3;
    localparam int ST_UNF  = 2;
    localparam int ST_INX  = 1;
    localparam int ST_ZERO = 0;

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_PACK, S_DONE} state_t;
endpackage

// File: rtl/fpu_normalizer.sv
// fpu_normalizer: iterative one-shift-per-cycle normalizer, truncation and packing stage
// following the FPU adder, with valid/ready on both sides.
module fpu_normalizer
    import fpu_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [EXP_W-1:0]   in_exp,
    input  logic [MAN_W+1:0]   in_mant,
    input  logic               in_sticky,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  data_out,
    output logic [3:0]         status_out
);
    state_t                    state;
    logic                      sign;
    logic                      inexact;
    logic                      zero_f;
    logic                      unf_f;
    logic [MAN_W+1:0]          mant;
    logic signed [IEXP_W-1:0]  expo;
    logic                      accept;
    logic                      norm_done;
    logic [DATA_W-1:0]         pack_data;
    logic [3:0]                pack_status;

    assign in_ready = state == S_IDLE;
    assign accept   = in_valid && in_ready;

    // Leaving S_NORM: zero, or no carry and either normalized or out of exponent range.
    always_comb begin
        norm_done   = mant == '0 || (!mant[MAN_W+1] && (mant[MAN_W] || expo <= EXP_ONE));
        pack_data   = {sign, expo[EXP_W-1:0], mant[MAN_W-1:0]};
        pack_status = '0;
        pack_status[ST_INX] = inexact;
        if (zero_f) begin
            pack_data   = '0;
            pack_status = '0;
            pack_status[ST_ZERO] = 1'b1;
        end else if (unf_f) begin
            pack_data = {sign, {(EXP_W + MAN_W){1'b0}}};
            pack_status[ST_UNF]  = 1'b1;
            pack_status[ST_ZERO] = 1'b1;
        end else if (expo >= EXP_MAX) begin
            pack_data   = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pack_status = '0;
            pack_status[ST_OVF] = 1'b1;
            pack_status[ST_INX] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            out_valid  <= 1'b0;
            data_out   <= '0;
            status_out <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) state <= S_NORM;
                S_NORM: if (norm_done) state <= S_PACK;
                S_PACK: begin
                    state      <= S_DONE;
                    out_valid  <= 1'b1;
                    data_out   <= pack_data;
                    status_out <= pack_status;
                end
                S_DONE: if (out_ready) begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sign    <= 1'b0;
            inexact <= 1'b0;
            zero_f  <= 1'b0;
            unf_f   <= 1'b0;
            mant    <= '0;
            expo    <= '0;
        end else if (accept) begin
            sign    <= in_sign;
            inexact <= in_sticky;
            zero_f  <= 1'b0;
            unf_f   <= 1'b0;
            mant    <= in_mant;
            expo    <= {2'b00, in_exp};
        end else if (state == S_NORM) begin
            if (mant == '0) begin
                zero_f <= 1'b1;
            end else if (mant[MAN_W+1]) begin
                mant    <= mant >> 1;
                expo    <= expo + EXP_ONE;
                inexact <= inexact | mant[0];
            end else if (!mant[MAN_W]) begin
                if (expo <= EXP_ONE) begin
                    unf_f <= 1'b1;
                end else begin
                    mant <= mant << 1;
                    expo <= expo - EXP_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_fpu_normalizer.sv
// tb_fpu_normalizer: scoreboard bench for fpu_normalizer with a value-level reference model.
module tb_fpu_normalizer;
    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [5:0]  in_exp;
    logic [26:0] in_mant;
    logic        in_sticky;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   rand_ready = 0;
    bit   prev_valid = 0;

    fpu_normalizer dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .status_out(status_out)
    );

    initial clock = 0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #2;
        if (rand_ready) out_ready = $urandom_range(0, 3) != 0;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Value-level model: find the shift count from the leading one, then decide the outcome.
    function automatic exp_t model(input bit s, input int e, input logic [26:0] m, input bit st);
        exp_t        r;
        int          ee = e;
        logic [26:0] mm = m;
        bit          inx = st;
        int          msb = 0;
        int          n = 0;
        int          shifts = 0;
        logic [5:0]  e6;
        r.acc = 0;
        if (m == 0) begin
            r.d = 0;
            r.s = 4'b0001;
        end else if (m[26]) begin
            inx = inx | m[0];
            mm = m >> 1;
            ee = e + 1;
            shifts = 1;
        end else begin
            for (int i = 0; i < 26; i++) if (m[i]) msb = i;
            n = 25 - msb;
            if (n > 0 && e <= n) shifts = (e > 1) ? e - 1 : 0;
            else begin
                mm = m << n;
                ee = e - n;
                shifts = n;
            end
        end
        if (m != 0) begin
            if (n > 0 && e <= n) begin
                r.d = {s, 31'h0};
                r.s = {2'b01, inx, 1'b1};
            end else if (ee >= 63) begin
                r.d = {s, 6'h3f, 25'h0};
                r.s = 4'b1010;
            end else begin
                e6 = ee[5:0];
                r.d = {s, e6, mm[24:0]};
                r.s = {2'b00, inx, 1'b0};
            end
        end
        r.lat = 2 + shifts;
        return r;
    endfunction

    task automatic send(input bit s, input int e, input logic [26:0] m, input bit st, input bit track);
        int   w = 0;
        exp_t x;
        @(negedge clock);
        while (!in_ready && w < 1000) begin
            @(negedge clock);
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: in_ready stuck at 0, expected 1");
            return;
        end
        in_valid = 1;
        in_sign = s;
        in_exp = e[5:0];
        in_mant = m;
        in_sticky = st;
        @(posedge clock);
        #1;
        if (track) begin
            x = model(s, e, m, st);
            x.acc = cyc;
            q.push_back(x);
        end
        in_valid = 0;
    endtask

    task automatic drain();
        int w = 0;
        while (q.size() > 0 && w < 3000) begin
            @(negedge clock);
            w++;
        end
        chk("drain_queue_empty", q.size(), 0);
    endtask

    always @(negedge clock) begin
        if (reset && out_valid && !prev_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: data %0h with empty scoreboard", data_out);
            end else chk("latency", cyc - q[0].acc, q[0].lat);
        end
        if (reset && out_valid && out_ready && q.size() > 0) begin
            mon_e = q.pop_front();
            chk("data_out", data_out, mon_e.d);
            chk("status_out", status_out, mon_e.s);
        end
        prev_valid = out_valid;
    end

    initial begin
        int          w;
        int          e;
        int          mode;
        logic [26:0] m;
        reset = 0;
        in_valid = 0;
        in_sign = 0;
        in_exp = 0;
        in_mant = 0;
        in_sticky = 0;
        out_ready = 1;
        repeat (3) @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_status", status_out, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1;

        send(0, 31, 27'h4000000, 0, 1);
        send(0, 31, 27'h3000000, 0, 1);
        send(0, 31, 27'h0800000, 0, 1);
        send(0, 62, 27'h4000001, 0, 1);
        send(0, 2, 27'h0800000, 0, 1);
        send(1, 17, 27'h0, 1, 1);
        send(0, 31, 27'h4000001, 0, 1);
        send(1, 0, 27'h2000000, 1, 1);
        send(1, 40, 27'h0000001, 0, 1);
        drain();

        rand_ready = 0;
        @(posedge clock);
        #2 out_ready = 0;
        send(0, 31, 27'h3000000, 0, 1);
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clock);
            w++;
        end
        chk("hold_valid_seen", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_data_out", data_out, 32'h3F000000);
            chk("hold_in_ready", in_ready, 0);
        end
        @(posedge clock);
        #2 out_ready = 1;
        drain();

        send(0, 31, 27'h0000001, 0, 0);
        repeat (3) @(negedge clock);
        #1 reset = 0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_data_out", data_out, 0);
        chk("abort_status", status_out, 0);
        repeat (2) @(negedge clock);
        reset = 1;
        @(negedge clock);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_no_output", out_valid, 0);

        rand_ready = 1;
        for (int k = 0; k < 250; k++) begin
            e = $urandom_range(0, 63);
            mode = $urandom_range(0, 4);
            m = 27'($urandom);
            if (mode == 1) m = {1'b0, 1'b1, m[24:0]};
            else if (mode == 2) m = m >> $urandom_range(0, 26);
            else if (mode == 3) m = {1'b1, m[25:0]};
            else if (mode == 4 && $urandom_range(0, 3) == 0) m = 0;
            send($urandom_range(0, 1) == 1, e, m, $urandom_range(0, 1) == 1, 1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
        end
        drain();
        rand_ready = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
